alu_seq: RTL and testbench

- Clocked, handshaked successor of the combinational 8-bit ALU, parametrised in operand width.
- Accepts one operation per valid/ready transfer and returns a registered 2*WIDTH result with zero/error flags on a valid/ready output channel.
- Add, sub, mul and logic ops complete in one cycle. Divide is an iterative restoring divider taking WIDTH cycles and returns both quotient and remainder.
- Sits between the CPU decode/operand stage and writeback; backpressure from writeback stalls the block.

---
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq : handshaked ALU, single-cycle add/sub/mul/logic plus iterative
//           restoring divider. Optional ALU_SEQ_SAT_EN saturates add/sub. rev 1.0
// ----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [3:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 zero,
  output logic                 error
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef ALU_SEQ_SAT_EN
  localparam int EW = 2;
`else
  localparam int EW = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] ext_a, ext_b, res;
  logic               res_err;
`ifdef ALU_SEQ_SAT_EN
  logic               res_sat;
`endif
  logic               accept, start_div;

  logic [WIDTH-1:0]   rem, quo, dvs;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff, rem_nxt, quo_nxt;
  logic               fits;
  logic [EW-1:0]      err_code;

  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign out_valid = (state == DONE);
  assign error     = err_code[EW-1];
  assign accept    = in_valid & in_ready;
  assign start_div = (op == OP_DIV) & (in2 != '0);

  assign ext_a = {{WIDTH{1'b0}}, in1};
  assign ext_b = {{WIDTH{1'b0}}, in2};

  always_comb begin
    res     = '0;
    res_err = 1'b0;
`ifdef ALU_SEQ_SAT_EN
    res_sat = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        res = ext_a + ext_b;
`ifdef ALU_SEQ_SAT_EN
        if (res[WIDTH]) begin
          res     = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          res_sat = 1'b1;
        end
`endif
      end
      OP_SUB: begin
`ifdef ALU_SEQ_SAT_EN
        if (in1 < in2) begin
          res_sat = 1'b1;
        end else begin
          res = ext_a - ext_b;
        end
`else
        res = ext_a - ext_b;
`endif
      end
      OP_MUL: res = ext_a * ext_b;
      OP_DIV: res_err = (in2 == '0);
      OP_AND: res = {{WIDTH{1'b0}}, in1 & in2};
      OP_OR:  res = {{WIDTH{1'b0}}, in1 | in2};
      OP_XOR: res = {{WIDTH{1'b0}}, in1 ^ in2};
      default: res_err = 1'b1;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  // When the trial fits, the true difference is below dvs, so WIDTH bits suffice.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    fits    = (trial >= {1'b0, dvs});
    diff    = trial[WIDTH-1:0] - dvs;
    rem_nxt = fits ? diff : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = start_div ? DIV : DONE;
      DIV:  if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = start_div ? DIV : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      zero     <= 1'b0;
      err_code <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (start_div) begin
        rem <= '0;
        quo <= in1;
        dvs <= in2;
        cnt <= '0;
      end else begin
        out  <= res;
        zero <= (res == '0) & !res_err;
`ifdef ALU_SEQ_SAT_EN
        err_code <= {res_err, res_sat};
`else
        err_code <= res_err;
`endif
      end
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        out      <= {rem_nxt, quo_nxt};
        zero     <= ({rem_nxt, quo_nxt} == '0);
        err_code <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq : directed table-driven checks plus multi-cycle handshake sequences.
module tb_alu_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, error;
  logic [7:0]  in1, in2;
  logic [3:0]  op;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int n;
    in1 = vecs[idx].a; in2 = vecs[idx].b; op = vecs[idx].op;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk($sformatf("vec%0d_lat", idx), n, vecs[idx].lat);
    chk($sformatf("vec%0d_out", idx), out, vecs[idx].exp);
    chk($sformatf("vec%0d_zero", idx), zero, vecs[idx].z);
    chk($sformatf("vec%0d_err", idx), error, vecs[idx].e);
    @(posedge clk); #1;
  endtask

  initial begin
    int flag;
    logic [15:0] sexp;
    clk = 0; rst_n = 0; in_valid = 0; out_ready = 1; in1 = 0; in2 = 0; op = 0;

`ifdef ALU_SEQ_SAT_EN
    vecs[0]  = '{4'd0, 8'd200, 8'd100, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd1, 8'd5,   8'd7,   16'h0000, 1'b1, 1'b0, 1};
    vecs[13] = '{4'd0, 8'd255, 8'd255, 16'h00FF, 1'b0, 1'b0, 1};
`else
    vecs[0]  = '{4'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd1, 8'd5,   8'd7,   16'hFFFE, 1'b0, 1'b0, 1};
    vecs[13] = '{4'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1};
`endif
    vecs[2]  = '{4'd1, 8'd9,   8'd9,   16'h0000, 1'b1, 1'b0, 1};
    vecs[3]  = '{4'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'd2, 8'd0,   8'd7,   16'h0000, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9};
    vecs[6]  = '{4'd3, 8'd13,  8'd0,   16'h0000, 1'b0, 1'b1, 1};
    vecs[7]  = '{4'd3, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 9};
    vecs[8]  = '{4'd3, 8'd3,   8'd10,  16'h0300, 1'b0, 1'b0, 9};
    vecs[9]  = '{4'd4, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd5, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0, 1};
    vecs[11] = '{4'd6, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1};
    vecs[12] = '{4'd9, 8'd4,   8'd2,   16'h0000, 1'b0, 1'b1, 1};
    vecs[14] = '{4'd15, 8'd0,  8'd0,   16'h0000, 1'b0, 1'b1, 1};
    vecs[15] = '{4'd0, 8'd7,   8'd0,   16'h0007, 1'b0, 1'b0, 1};

    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_error", error, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Divider busy window: in_ready low for all 8 iteration cycles.
    in1 = 8'd200; in2 = 8'd7; op = 4'd3; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    flag = 0;
    for (int k = 1; k <= 8; k++) begin
      if (in_ready || out_valid) flag++;
      @(posedge clk); #1;
    end
    chk("div_busy", flag, 0);
    chk("div_done_valid", out_valid, 1);
    chk("div_done_out", out, 16'h041C);
    @(posedge clk); #1;

    // Backpressure: result held while a new request waits, then accepted on release.
    in1 = 8'd255; in2 = 8'd255; op = 4'd2; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in1 = 8'd1; in2 = 8'd2; op = 4'd0;
    flag = 0;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || out !== 16'hFE01 || in_ready || error) flag++;
      @(posedge clk); #1;
    end
    chk("hold_stable", flag, 0);
    out_ready = 1; #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_out", out, 16'h0003);
    @(posedge clk); #1;
    chk("b2b_idle", out_valid, 0);

    // Back-to-back stream of 10 single-cycle ops.
    out_ready = 1;
    in1 = 8'd0; in2 = 8'd7; op = 4'd0; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sexp = (i % 2 == 0) ? 16'(i * 20 + 7) : 16'((i * 20) ^ 7);
      chk($sformatf("stream%0d", i), {15'd0, out_valid, out}, {15'd0, 1'b1, sexp});
      if (i < 9) begin
        in1 = 8'((i + 1) * 20);
        op  = ((i + 1) % 2 == 0) ? 4'd0 : 4'd6;
      end else begin
        in_valid = 0;
      end
    end
    @(posedge clk); #1;
    chk("stream_end", out_valid, 0);

    // Reset during a division discards it.
    in1 = 8'd200; in2 = 8'd7; op = 4'd3; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_out", out, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("abort_release_ready", in_ready, 1);
    flag = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) flag++;
    end
    chk("abort_no_stale", flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
